// File: rtl/cpu_mon_pkg.sv
// Shared types and defaults for the CPU run-control monitor.
package cpu_mon_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 32;

  localparam logic [31:0] SYSCALL_INSTR = 32'h0000_000C;

  localparam logic [1:0] ST_HOLD_ENC    = 2'd0;
  localparam logic [1:0] ST_RUN_ENC     = 2'd1;
  localparam logic [1:0] ST_HALTED_ENC  = 2'd2;
  localparam logic [1:0] ST_TIMEOUT_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_HOLD    = ST_HOLD_ENC,
    ST_RUN     = ST_RUN_ENC,
    ST_HALTED  = ST_HALTED_ENC,
    ST_TIMEOUT = ST_TIMEOUT_ENC
  } state_t;

endpackage

// File: rtl/cpu_trace_buf.sv
// Circular PC trace buffer; index 0 reads the most recently written entry.
module cpu_trace_buf
  import cpu_mon_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int TRACE_DEPTH = 8,
  localparam int IDX_W      = $clog2(TRACE_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_data,
  input  logic                  clr,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [ADDR_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  logic [ADDR_WIDTH-1:0]  mem [TRACE_DEPTH];
  logic [TRACE_DEPTH-1:0] vld;
  logic [IDX_W-1:0]       wptr;
  logic [IDX_W-1:0]       rd_addr;

  assign rd_addr  = wptr - IDX_W'(1) - rd_idx;
  assign rd_valid = vld[rd_addr];
  // Invalid entries read as zero so the output never exposes unwritten storage.
  assign rd_data  = vld[rd_addr] ? mem[rd_addr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld  <= '0;
      wptr <= '0;
    end else if (clr) begin
      vld  <= '0;
      wptr <= '0;
    end else if (wr_en) begin
      vld[wptr] <= 1'b1;
      wptr      <= wptr + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control monitor: CPU reset pulse, cycle count, halt/timeout detection, PC trace.
// Optional trace storage is built only when CPU_MON_TRACE_EN is defined.
module cpu_run_monitor
  import cpu_mon_pkg::*;
#(
  parameter int          ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int          CNT_WIDTH       = DEF_CNT_WIDTH,
  parameter int          RESET_CYCLES    = 2,
  parameter int          TIMEOUT_CYCLES  = 100,
  parameter int          SELF_LOOP_COUNT = 2,
  parameter int          TRACE_DEPTH     = 8,
  parameter logic [31:0] SYSCALL_WORD    = SYSCALL_INSTR,
  localparam int         IDX_W           = $clog2(TRACE_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [31:0]           instr,
  input  logic                  restart,
  output logic                  cpu_reset,
  output logic                  running,
  output logic                  halted,
  output logic                  timeout,
  output logic [ADDR_WIDTH-1:0] halt_pc,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  input  logic [IDX_W-1:0]      trace_idx,
  output logic [ADDR_WIDTH-1:0] trace_pc,
  output logic                  trace_valid
);

  localparam int HOLD_W  = $clog2(RESET_CYCLES + 1);
  localparam int STALL_W = $clog2(SELF_LOOP_COUNT + 1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST    = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [STALL_W-1:0]   STALL_LAST   = STALL_W'(SELF_LOOP_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                state;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [STALL_W-1:0]    stall_cnt;
  logic                  prev_vld;
  logic [ADDR_WIDTH-1:0] prev_pc;

  logic in_run;
  logic do_restart;
  logic syscall_hit;
  logic pc_same;
  logic loop_hit;
  logic halt_hit;
  logic timeout_hit;

  assign in_run      = (state == ST_RUN);
  assign do_restart  = restart && (state != ST_HOLD);
  assign syscall_hit = (instr == SYSCALL_WORD);
  assign pc_same     = prev_vld && (pc == prev_pc);
  // This cycle's repeat is the SELF_LOOP_COUNT-th consecutive one.
  assign loop_hit    = pc_same && (stall_cnt == STALL_LAST);
  assign halt_hit    = syscall_hit || loop_hit;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_count == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_HOLD;
      hold_cnt    <= '0;
      stall_cnt   <= '0;
      prev_vld    <= 1'b0;
      cycle_count <= '0;
      halt_pc     <= '0;
    end else if (do_restart) begin
      state       <= ST_HOLD;
      hold_cnt    <= '0;
      stall_cnt   <= '0;
      prev_vld    <= 1'b0;
      cycle_count <= '0;
      halt_pc     <= '0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= ST_RUN;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + CNT_WIDTH'(1);
          prev_vld  <= 1'b1;
          stall_cnt <= pc_same ? stall_cnt + STALL_W'(1) : '0;
          if (halt_hit) begin
            state   <= ST_HALTED;
            halt_pc <= pc;
          end else if (timeout_hit) begin
            state   <= ST_TIMEOUT;
            halt_pc <= pc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (in_run) prev_pc <= pc;
  end

  assign cpu_reset = (state == ST_HOLD);
  assign running   = in_run;
  assign halted    = (state == ST_HALTED);
  assign timeout   = (state == ST_TIMEOUT);

`ifdef CPU_MON_TRACE_EN
  cpu_trace_buf #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (in_run && !do_restart),
    .wr_data  (pc),
    .clr      (do_restart),
    .rd_idx   (trace_idx),
    .rd_data  (trace_pc),
    .rd_valid (trace_valid)
  );
`else
  logic unused_trace_idx;
  assign unused_trace_idx = ^trace_idx;
  assign trace_pc         = '0;
  assign trace_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor with default parameters.
module tb_cpu_run_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        restart;
  logic        cpu_reset;
  logic        running;
  logic        halted;
  logic        timeout;
  logic [31:0] halt_pc;
  logic [31:0] cycle_count;
  logic [2:0]  trace_idx;
  logic [31:0] trace_pc;
  logic        trace_valid;

  int nvec  = 0;
  int nfail = 0;

  cpu_run_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .instr       (instr),
    .restart     (restart),
    .cpu_reset   (cpu_reset),
    .running     (running),
    .halted      (halted),
    .timeout     (timeout),
    .halt_pc     (halt_pc),
    .cycle_count (cycle_count),
    .trace_idx   (trace_idx),
    .trace_pc    (trace_pc),
    .trace_valid (trace_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic cr, input logic run,
                         input logic hlt, input logic to, input logic [31:0] cnt);
    chk({tag, ".cpu_reset"}, cpu_reset, cr);
    chk({tag, ".running"}, running, run);
    chk({tag, ".halted"}, halted, hlt);
    chk({tag, ".timeout"}, timeout, to);
    chk({tag, ".cycle_count"}, cycle_count, cnt);
  endtask

  task automatic chk_trace(input string tag, input logic [2:0] idx,
                           input logic [31:0] epc, input logic evld);
    trace_idx = idx;
    #1;
`ifdef CPU_MON_TRACE_EN
    chk({tag, ".trace_pc"}, trace_pc, epc);
    chk({tag, ".trace_valid"}, trace_valid, evld);
`else
    chk({tag, ".trace_pc"}, trace_pc, 32'd0);
    chk({tag, ".trace_valid"}, trace_valid, 1'b0);
`endif
  endtask

  initial begin
    reset     = 1'b1;
    pc        = 32'd0;
    instr     = 32'd0;
    restart   = 1'b0;
    trace_idx = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_ctl("rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("rst.halt_pc", halt_pc, 32'd0);
    chk_trace("rst", 3'd0, 32'd0, 1'b0);
    reset = 1'b0;

    // Reset release: two hold edges, then counting begins
    tick(); chk_ctl("hold1", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(); chk_ctl("run0", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    tick(); chk_ctl("run1", 1'b0, 1'b1, 1'b0, 1'b0, 32'd1); pc = 32'd4;
    tick(); chk_ctl("run2", 1'b0, 1'b1, 1'b0, 1'b0, 32'd2); pc = 32'd8;
    tick(); chk_ctl("run3", 1'b0, 1'b1, 1'b0, 1'b0, 32'd3);
    pc = 32'd12; instr = 32'h0000_000C;
    tick(); chk_ctl("sys", 1'b0, 1'b0, 1'b1, 1'b0, 32'd4);
    chk("sys.halt_pc", halt_pc, 32'd12);
    instr = 32'd0; pc = 32'd16;
    tick(); chk_ctl("sys.frozen", 1'b0, 1'b0, 1'b1, 1'b0, 32'd4);
    chk_trace("sys.t0", 3'd0, 32'd12, 1'b1);
    chk_trace("sys.t3", 3'd3, 32'd0, 1'b1);
    chk_trace("sys.t4", 3'd4, 32'd0, 1'b0);

    // Restart from HALTED; a second restart while in HOLD is ignored
    restart = 1'b1; pc = 32'd0; trace_idx = 3'd0;
    tick(); chk_ctl("rs.hold1", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("rs.halt_pc", halt_pc, 32'd0);
    chk_trace("rs", 3'd0, 32'd0, 1'b0);
    tick(); chk_ctl("rs.hold2", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    restart = 1'b0;
    tick(); chk_ctl("rs.run", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Self loop: 0, 4, 8, 8, 8
    tick(); pc = 32'd4;
    tick(); pc = 32'd8;
    tick(); chk("loop.c3", cycle_count, 32'd3);
    tick(); chk_ctl("loop.rep1", 1'b0, 1'b1, 1'b0, 1'b0, 32'd4);
    tick(); chk_ctl("loop.rep2", 1'b0, 1'b0, 1'b1, 1'b0, 32'd5);
    chk("loop.halt_pc", halt_pc, 32'd8);
    chk_trace("loop.t0", 3'd0, 32'd8, 1'b1);
    chk_trace("loop.t4", 3'd4, 32'd0, 1'b1);

    // Timeout after 100 RUN cycles of advancing PC
    restart = 1'b1; pc = 32'd0;
    tick(); restart = 1'b0;
    tick(); tick();
    chk_ctl("to.run0", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 99; i++) begin
      tick(); pc = pc + 32'd4;
    end
    chk_ctl("to.c99", 1'b0, 1'b1, 1'b0, 1'b0, 32'd99);
    tick(); chk_ctl("to.hit", 1'b0, 1'b0, 1'b0, 1'b1, 32'd100);
    chk("to.halt_pc", halt_pc, 32'd396);
    tick(); chk_ctl("to.frozen", 1'b0, 1'b0, 1'b0, 1'b1, 32'd100);

    // Syscall on the timeout cycle: halt wins
    restart = 1'b1; pc = 32'd0;
    tick(); chk_ctl("to.rs", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    restart = 1'b0;
    tick(); tick();
    for (int i = 0; i < 99; i++) begin
      tick(); pc = pc + 32'd4;
    end
    instr = 32'h0000_000C;
    tick(); chk_ctl("tie", 1'b0, 1'b0, 1'b1, 1'b0, 32'd100);
    chk("tie.halt_pc", halt_pc, 32'd396);
    instr = 32'd0;

    // Trace wrap: ten sequential PCs 0..36
    restart = 1'b1; pc = 32'd0;
    tick(); restart = 1'b0;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      tick(); pc = pc + 32'd4;
    end
    chk_ctl("wrap", 1'b0, 1'b1, 1'b0, 1'b0, 32'd10);
    chk_trace("wrap.t0", 3'd0, 32'd36, 1'b1);
    chk_trace("wrap.t7", 3'd7, 32'd8, 1'b1);

    // Asynchronous reset mid-RUN
    #2 reset = 1'b1;
    #1;
    chk_ctl("arst", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("arst.halt_pc", halt_pc, 32'd0);
    chk_trace("arst", 3'd0, 32'd0, 1'b0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
